arm_decode_seq: RTL

//  Registered ARM7TDMI decode stage: classifies each 32-bit instruction from

---
 rtl/arm_decode_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/arm_decode_seq.sv
// ARM7TDMI decode stage: instruction class, condition check, and
// LDM/STM expansion into one micro-op per listed register.
module arm_decode_seq #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter bit COND_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_class,
    output logic [3:0]       out_opcode,
    output logic             out_cond_pass,
    output logic [IDX_W-1:0] out_reg,
    output logic             out_load,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam logic [2:0] CLS_DP     = 3'd0;
    localparam logic [2:0] CLS_LDST   = 3'd1;
    localparam logic [2:0] CLS_LDMSTM = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_OTHER  = 3'd4;
    localparam logic [2:0] CLS_NOP    = 3'd5;

    localparam logic [NUM_REGS-1:0] ONE       = NUM_REGS'(1);
    localparam logic [IDX_W-1:0]    EMPTY_REG = IDX_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE,
        MULTI
    } state_t;

    state_t              state;
    logic [NUM_REGS-1:0] remaining;

    logic                accept;
    logic                pass;
    logic [2:0]          cls_raw;
    logic [NUM_REGS-1:0] list;
    logic [NUM_REGS-1:0] list_rest;
    logic [NUM_REGS-1:0] rem_next;
    logic [NUM_REGS-1:0] rem_after;

    // Index of the lowest set bit; ascending register order.
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_REGS-1:0] v);
        lowest = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        unique case (c)
            4'h0: cond_eval = z;
            4'h1: cond_eval = !z;
            4'h2: cond_eval = cy;
            4'h3: cond_eval = !cy;
            4'h4: cond_eval = n;
            4'h5: cond_eval = !n;
            4'h6: cond_eval = v;
            4'h7: cond_eval = !v;
            4'h8: cond_eval = cy && !z;
            4'h9: cond_eval = !cy || z;
            4'hA: cond_eval = (n == v);
            4'hB: cond_eval = (n != v);
            4'hC: cond_eval = !z && (n == v);
            4'hD: cond_eval = z || (n != v);
            4'hE: cond_eval = 1'b1;
            4'hF: cond_eval = 1'b0;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign pass     = COND_EN ? cond_eval(in_instr[31:28], in_flags) : 1'b1;
    assign list     = in_instr[NUM_REGS-1:0];

    always_comb begin
        cls_raw = CLS_OTHER;
        unique case (in_instr[27:25])
            3'b000, 3'b001: cls_raw = CLS_DP;
            3'b010, 3'b011: cls_raw = CLS_LDST;
            3'b100:         cls_raw = CLS_LDMSTM;
            3'b101:         cls_raw = CLS_BRANCH;
            3'b110, 3'b111: cls_raw = CLS_OTHER;
        endcase
    end

    // x & (x-1) drops the lowest set bit; zero result means one bit was left.
    assign list_rest = list & (list - ONE);
    assign rem_next  = remaining & (remaining - ONE);
    assign rem_after = rem_next & (rem_next - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            out_instr     <= '0;
            out_class     <= '0;
            out_opcode    <= '0;
            out_cond_pass <= 1'b0;
            out_reg       <= '0;
            out_load      <= 1'b0;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        out_valid     <= 1'b1;
                        out_instr     <= in_instr;
                        out_opcode    <= in_instr[24:21];
                        out_load      <= in_instr[20];
                        out_first     <= 1'b1;
                        out_last      <= 1'b1;
                        out_cond_pass <= pass;
                        out_reg       <= '0;
                        if (!pass) begin
                            out_class <= CLS_NOP;
                        end else if (cls_raw == CLS_LDMSTM && |list) begin
                            state     <= MULTI;
                            busy      <= 1'b1;
                            remaining <= list;
                            out_class <= CLS_LDMSTM;
                            out_reg   <= lowest(list);
                            out_last  <= (list_rest == '0);
                        end else if (cls_raw == CLS_LDMSTM) begin
                            out_class <= CLS_LDMSTM;
                            out_reg   <= EMPTY_REG;
                        end else begin
                            out_class <= cls_raw;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MULTI: begin
                    if (out_ready) begin
                        out_first <= 1'b0;
                        if (out_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            remaining <= '0;
                        end else begin
                            remaining <= rem_next;
                            out_reg   <= lowest(rem_next);
                            out_last  <= (rem_after == '0);
                        end
                    end
                end
            endcase
        end
    end

endmodule
